// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the multi-cycle multiply/divide engine:
//   muldiv_funct_t  - operation selector from the decoder (NCARE = no operation)
//   muldiv_state_t  - FSM state encoding (IDLE, MUL, DIV, FIX, DONE)
//   muldiv_result_t - packed {hi, lo} result written to the HI/LO registers
//   DIV_ITERS       - restoring-divider iteration count (one quotient bit each)
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULDIV_NCARE = 3'd0,
    MULDIV_MULT  = 3'd1,
    MULDIV_MULTU = 3'd2,
    MULDIV_DIV   = 3'd3,
    MULDIV_DIVU  = 3'd4
  } muldiv_funct_t;

  typedef logic [2:0] muldiv_state_t;

  localparam muldiv_state_t ST_IDLE = 3'd0;
  localparam muldiv_state_t ST_MUL  = 3'd1;
  localparam muldiv_state_t ST_DIV  = 3'd2;
  localparam muldiv_state_t ST_FIX  = 3'd3;
  localparam muldiv_state_t ST_DONE = 3'd4;

  localparam int DIV_ITERS = 32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } muldiv_result_t;

  // States in which an operation is still computing (result not yet available).
  function automatic logic in_flight(input muldiv_state_t s);
    return (s == ST_MUL) || (s == ST_DIV) || (s == ST_FIX);
  endfunction

  // Two's-complement negate when n is set.
  function automatic logic [31:0] negate_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
// Unsigned 32-bit restoring divider, one quotient bit per step.
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   load_i       capture dividend/divisor, clear the partial remainder
//   step_i       perform one shift/trial-subtract iteration
//   dividend_i   32-bit unsigned dividend
//   divisor_i    32-bit unsigned divisor
//   quotient_o   quotient after 32 steps
//   remainder_o  remainder after 32 steps
// A zero divisor never borrows, so 32 steps yield quotient=FFFFFFFF and
// remainder=dividend, which is the defined divide-by-zero result.
// -----------------------------------------------------------------------------
module muldiv_div_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q;
  logic [32:0] partial;
  logic [32:0] trial;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    partial = {rem_q, quo_q[31]};
    trial   = partial - {1'b0, dsr_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    if (step_i) begin
      if (trial[32]) begin
        rem_d = partial[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end else begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dsr_q <= divisor_i;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing the 64-bit {hi,lo} result.
//   clk    clock, rising edge
//   reset  synchronous, active-high; returns to IDLE and clears hi/lo
//   start  launch an operation; accepted only in IDLE or DONE
//   funct  operation selector; MULDIV_NCARE with start is a no-op
//   a, b   $rs / $rt operands, captured on the accepting edge
//   flush  abort any in-flight operation; hi/lo are left untouched
//   busy   registered; high while an accepted op is computing
//   done   one-cycle pulse: hi/lo hold a fresh result this cycle
//   hi     MUL: product[63:32]   DIV: remainder
//   lo     MUL: product[31:0]    DIV: quotient
// Latency from the accepting edge to done: MUL_CYCLES for multiplies, 34 for
// divides (1 operand-conditioning cycle, 32 iterations, 1 sign-fix cycle).
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  muldiv_funct_t funct,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [31:0]   hi,
  output logic [31:0]   lo
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS);

  muldiv_state_t  state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  muldiv_result_t res_q;
  logic [63:0]    prod_q;
  logic [31:0]    op_a_q, op_b_q;
  logic           div_signed_q;

  logic           is_mul_op, is_div_op, accept;
  logic           mul_ext;
  logic [63:0]    mul_a, mul_b;
  logic           div_load, div_step;
  logic [31:0]    quo_raw, rem_raw;
  logic           neg_quo, neg_rem;
  logic [31:0]    quo_fix, rem_fix;

  assign is_mul_op = (funct == MULDIV_MULT) || (funct == MULDIV_MULTU);
  assign is_div_op = (funct == MULDIV_DIV)  || (funct == MULDIV_DIVU);
  assign accept    = start && !flush && (is_mul_op || is_div_op) &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Operands extended to 64 bits; the low 64 bits of the product are correct
  // for both signed and unsigned interpretation.
  assign mul_ext = (funct == MULDIV_MULT);
  assign mul_a   = {{32{mul_ext & a[31]}}, a};
  assign mul_b   = {{32{mul_ext & b[31]}}, b};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_load = 1'b0;
    div_step = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_d = is_mul_op ? ST_MUL : ST_DIV;
            cnt_d   = is_mul_op ? MUL_LOAD : 6'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_q == 6'd0) state_d = ST_DONE;
          else               cnt_d   = cnt_q - 6'd1;
        end
        ST_DIV: begin
          // First DIV cycle hands the operand magnitudes to the core; the
          // following DIV_ITERS cycles each retire one quotient bit.
          if (cnt_q == 6'd0) begin
            div_load = 1'b1;
            cnt_d    = 6'd1;
          end else begin
            div_step = 1'b1;
            if (cnt_q == DIV_LAST) state_d = ST_FIX;
            else                   cnt_d   = cnt_q + 6'd1;
          end
        end
        ST_FIX:  state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // busy stays low on the accepting edge and drops as the result commits.
  assign busy_d = in_flight(state_q) && in_flight(state_d);

  muldiv_div_core u_div_core (
    .clk         (clk),
    .reset       (reset),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (negate_if(div_signed_q & op_a_q[31], op_a_q)),
    .divisor_i   (negate_if(div_signed_q & op_b_q[31], op_b_q)),
    .quotient_o  (quo_raw),
    .remainder_o (rem_raw)
  );

  // Quotient sign flips only for a real (non-zero) divisor; the remainder
  // always follows the dividend. 80000000/FFFFFFFF wraps to 80000000.
  assign neg_quo = div_signed_q && (op_a_q[31] ^ op_b_q[31]) && (op_b_q != 32'd0);
  assign neg_rem = div_signed_q && op_a_q[31];
  assign quo_fix = negate_if(neg_quo, quo_raw);
  assign rem_fix = negate_if(neg_rem, rem_raw);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      res_q        <= '0;
      prod_q       <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      div_signed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      if (accept) begin
        op_a_q       <= a;
        op_b_q       <= b;
        div_signed_q <= (funct == MULDIV_DIV);
        if (is_mul_op) prod_q <= mul_a * mul_b;
      end
      // DONE is only entered from MUL or FIX, never under flush.
      if (state_d == ST_DONE) begin
        res_q <= (state_q == ST_MUL) ? muldiv_result_t'(prod_q)
                                     : muldiv_result_t'({rem_fix, quo_fix});
      end
    end
  end

  assign busy = busy_q;
  assign done = (state_q == ST_DONE);
  assign hi   = res_q.hi;
  assign lo   = res_q.lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboarded bench for muldiv_unit: stimulus pushes the expected {hi,lo} and
// due cycle per launched op; a separate monitor pops and compares on each done.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MUL_CYCLES = 3;
  localparam int DIV_LAT    = 34;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  muldiv_funct_t funct = MULDIV_NCARE;
  logic [31:0]   a     = '0;
  logic [31:0]   b     = '0;
  logic          busy, done;
  logic [31:0]   hi, lo;

  muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   hi;
    logic [31:0]   lo;
    int            due;
    muldiv_funct_t f;
    logic [31:0]   x;
    logic [31:0]   y;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  // Reference model: plain integer arithmetic plus the defined special cases.
  function automatic logic [63:0] model(input muldiv_funct_t f, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy, q, r;
    case (f)
      MULDIV_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return 64'(sp);
      end
      MULDIV_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        return up;
      end
      MULDIV_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      MULDIV_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {32'(r), 32'(q)};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int lat(input muldiv_funct_t f);
    return (f == MULDIV_MULT || f == MULDIV_MULTU) ? MUL_CYCLES : DIV_LAT;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents done.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sb.size() > 0 && cyc > sb[0].due) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL done_missing %s a=%h b=%h: no done, required at cycle %0d",
                   e.f.name(), e.x, e.y, e.due);
        end
        if (done) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: hi=%h lo=%h at cycle %0d, required no done",
                     hi, lo, cyc);
          end else begin
            e = sb.pop_front();
            if (hi !== e.hi || lo !== e.lo || cyc != e.due) begin
              errors++;
              $display("FAIL result %s a=%h b=%h: got hi=%h lo=%h cycle %0d, required hi=%h lo=%h cycle %0d",
                       e.f.name(), e.x, e.y, hi, lo, cyc, e.hi, e.lo, e.due);
            end else begin
              $display("ok %s a=%h b=%h -> hi=%h lo=%h at cycle %0d",
                       e.f.name(), e.x, e.y, hi, lo, cyc);
            end
            last_hi = e.hi;
            last_lo = e.lo;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive start for one cycle (call at a negedge). Returns the accepting edge.
  task automatic launch(input muldiv_funct_t f, input logic [31:0] x, input logic [31:0] y,
                        input bit push, output int e);
    logic [63:0] r;
    exp_t        ent;
    start = 1'b1;
    funct = f;
    a     = x;
    b     = y;
    e     = cyc + 1;
    if (push) begin
      r       = model(f, x, y);
      ent.hi  = r[63:32];
      ent.lo  = r[31:0];
      ent.due = e + lat(f);
      ent.f   = f;
      ent.x   = x;
      ent.y   = y;
      sb.push_back(ent);
    end
    @(negedge clk);
    // Scramble inputs after acceptance: the DUT must have latched them.
    start = 1'b0;
    funct = muldiv_funct_t'(3'($urandom_range(0, 4)));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Launch an op and follow it to its done cycle, checking the busy window.
  task automatic run_op(input muldiv_funct_t f, input logic [31:0] x, input logic [31:0] y);
    int e, n;
    bit ok;
    launch(f, x, y, 1'b1, e);
    n  = lat(f);
    ok = (busy === 1'b0);
    while (cyc < e + n) begin
      @(negedge clk);
      if (busy !== ((cyc <= e + n - 1) ? 1'b1 : 1'b0)) ok = 1'b0;
    end
    chk($sformatf("busy_window_%s", f.name()), 32'(ok), 32'd1);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (sb.size() > 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d ops still outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : stimulus
    int          e;
    bit          ok;
    muldiv_funct_t rf;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // Directed arithmetic and latency cases.
    run_op(MULDIV_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    run_op(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MULDIV_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MULDIV_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_op(MULDIV_DIVU,  32'd100,       32'd7);
    run_op(MULDIV_DIVU,  32'd5,         32'd0);
    run_op(MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MULDIV_DIV,   32'hFFFF_FFF0, 32'd0);
    repeat (2) @(negedge clk);

    // Flush 10 cycles into a DIV: no done, hi/lo keep the previous result.
    launch(MULDIV_DIV, 32'd1234567, 32'd89, 1'b0, e);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_hi_hold", hi, last_hi);
    chk("flush_lo_hold", lo, last_lo);
    run_op(MULDIV_MULT, 32'd7, 32'hFFFF_FFFA);
    @(negedge clk);

    // flush and start together: start is dropped.
    start = 1'b1;
    funct = MULDIV_MULT;
    a     = 32'd11;
    b     = 32'd13;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    ok = 1'b1;
    repeat (MUL_CYCLES + 3) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 1'b0;
    end
    chk("flush_start_idle", 32'(ok), 32'd1);
    chk("flush_start_lo_hold", lo, last_lo);

    // start while busy is ignored; the DIV result is unaffected.
    launch(MULDIV_DIV, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, e);
    repeat (5) @(negedge clk);
    start = 1'b1;
    funct = MULDIV_MULT;
    a     = 32'd3;
    b     = 32'd4;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (MUL_CYCLES + 2) @(negedge clk);

    // Back-to-back issue in the DONE cycle.
    run_op(MULDIV_MULT,  32'h1234_5678, 32'h9ABC_DEF0);
    run_op(MULDIV_MULTU, 32'h8000_0001, 32'h0000_0010);
    run_op(MULDIV_DIV,   32'h7FFF_FFFF, 32'hFFFF_FFFD);
    run_op(MULDIV_MULT,  32'h8000_0000, 32'h8000_0000);

    // Reset in the middle of a MUL.
    launch(MULDIV_MULT, 32'd5, 32'd6, 1'b0, e);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    last_hi = '0;
    last_lo = '0;

    // Randomized ops, random gaps (zero gap = back-to-back).
    for (int i = 0; i < 40; i++) begin
      rf = muldiv_funct_t'(3'($urandom_range(1, 4)));
      run_op(rf, rand_operand(), rand_operand());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(60);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
